// File: rtl/vend_if.sv
// vend_if: controller <-> money-input/dispenser signal bundle; master = controller side.
// The cancel wire exists only when CANCEL_EN is defined.
interface vend_if;
  logic [15:0] total;
  logic select_valid;
  logic [1:0] select_id;
  logic [3:0] stock_empty;
  logic dispense_req;
  logic [1:0] dispense_id;
  logic dispense_ack;
  logic coin_valid;
  logic [3:0] coin_type;
  logic coin_ready;
  logic credit_clear;
  logic busy;
  logic [3:0] error;
`ifdef CANCEL_EN
  logic cancel;
  modport master (
    input total, select_valid, select_id, stock_empty, dispense_ack, coin_ready, cancel,
    output dispense_req, dispense_id, coin_valid, coin_type, credit_clear, busy, error
  );
  modport slave (
    output total, select_valid, select_id, stock_empty, dispense_ack, coin_ready, cancel,
    input dispense_req, dispense_id, coin_valid, coin_type, credit_clear, busy, error
  );
`else
  modport master (
    input total, select_valid, select_id, stock_empty, dispense_ack, coin_ready,
    output dispense_req, dispense_id, coin_valid, coin_type, credit_clear, busy, error
  );
  modport slave (
    output total, select_valid, select_id, stock_empty, dispense_ack, coin_ready,
    input dispense_req, dispense_id, coin_valid, coin_type, credit_clear, busy, error
  );
`endif
endinterface

// File: rtl/vend_controller.sv
// vend_controller: select check, dispense handshake, greedy change payout, credit clear.
// Define CANCEL_EN to add a cancel input that refunds the full credit from IDLE.
module vend_controller #(
  parameter int NUM_PRODUCTS = 4,
  parameter logic [15:0] PRICE0 = 16'd1500,
  parameter logic [15:0] PRICE1 = 16'd2000,
  parameter logic [15:0] PRICE2 = 16'd3500,
  parameter logic [15:0] PRICE3 = 16'd5000,
  parameter int TIMEOUT = 255
) (
  input logic clock,
  input logic reset,
  vend_if.master bus
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, CHECK, VEND, CHANGE, DONE} state_t;
  state_t state, state_d;
  logic [15:0] rem, rem_d, price, price_d, coin_val;
  logic [TW-1:0] timer, timer_d;
  logic [1:0] id, id_d;
  logic [3:0] err, err_d, coin;
  logic cancel_go;
`ifdef CANCEL_EN
  assign cancel_go = bus.cancel && bus.total != 16'd0;
`else
  assign cancel_go = 1'b0;
`endif
  function automatic logic [15:0] price_of(input logic [1:0] i);
    return i == 2'd0 ? PRICE0 : i == 2'd1 ? PRICE1 : i == 2'd2 ? PRICE2 : PRICE3;
  endfunction
  // Largest coin not exceeding the remainder; 500 is the floor once rem >= 500.
  assign coin = rem >= 16'd5000 ? 4'b1000 : rem >= 16'd2000 ? 4'b0100 : rem >= 16'd1000 ? 4'b0010 : 4'b0001;
  assign coin_val = coin[3] ? 16'd5000 : coin[2] ? 16'd2000 : coin[1] ? 16'd1000 : 16'd500;
  assign bus.busy = state != IDLE;
  assign bus.error = err;
  always_comb begin
    state_d = state;
    rem_d = rem;
    timer_d = timer;
    id_d = id;
    price_d = price;
    err_d = err;
    bus.dispense_req = 1'b0;
    bus.dispense_id = 2'd0;
    bus.coin_valid = 1'b0;
    bus.coin_type = 4'd0;
    bus.credit_clear = 1'b0;
    case (state)
      IDLE:
        if (bus.select_valid) begin
          id_d = bus.select_id;
          price_d = price_of(bus.select_id);
          err_d = 4'd0;
          state_d = CHECK;
        end else if (cancel_go) begin
          rem_d = bus.total;
          state_d = CHANGE;
        end
      CHECK:
        if (int'(id) >= NUM_PRODUCTS) begin
          err_d = 4'b0100;
          state_d = IDLE;
        end else if (bus.stock_empty[id]) begin
          err_d = 4'b0010;
          state_d = IDLE;
        end else if (bus.total < price) begin
          err_d = 4'b0001;
          state_d = IDLE;
        end else begin
          rem_d = bus.total - price;
          timer_d = '0;
          state_d = VEND;
        end
      VEND: begin
        bus.dispense_req = 1'b1;
        bus.dispense_id = id;
        if (bus.dispense_ack) state_d = CHANGE;
        else if (timer == TW'(TIMEOUT - 1)) begin
          err_d = 4'b1000;
          state_d = IDLE;
        end else timer_d = timer + 1'b1;
      end
      CHANGE: begin
        bus.coin_valid = rem >= 16'd500;
        bus.coin_type = bus.coin_valid ? coin : 4'd0;
        if (!bus.coin_valid) state_d = DONE;
        else if (bus.coin_ready) rem_d = rem - coin_val;
      end
      DONE: begin
        bus.credit_clear = 1'b1;
        rem_d = 16'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      rem <= '0;
      timer <= '0;
      id <= '0;
      price <= '0;
      err <= '0;
    end else begin
      state <= state_d;
      rem <= rem_d;
      timer <= timer_d;
      id <= id_d;
      price <= price_d;
      err <= err_d;
    end
endmodule

// File: tb/tb_vend_controller.sv
// tb_vend_controller: directed transactions; expected events queued, monitor pops and compares.
// Slot 3 is configured out (NUM_PRODUCTS=3) so the invalid-id path is reachable.
module tb_vend_controller;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int n_vec = 0;
  int n_fail = 0;
  int cyc = 0;
  int sel_cyc = 0;
  typedef enum int {K_DISP, K_COIN, K_CLR, K_END} kind_t;
  typedef struct {kind_t k; logic [3:0] v;} exp_t;
  exp_t exp_q[$];
  logic req_prev = 1'b0, busy_prev = 1'b0, stall_prev = 1'b0;
  logic [3:0] type_prev = 4'd0;
  logic [13:0] outs;
  vend_if bus();
  vend_controller #(.NUM_PRODUCTS(3)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  assign outs = {bus.dispense_req, bus.dispense_id, bus.coin_valid, bus.coin_type,
                 bus.credit_clear, bus.busy, bus.error};
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask
  task automatic expect_ev(input kind_t k, input logic [3:0] v);
    exp_q.push_back('{k, v});
  endtask
  task automatic check_ev(input kind_t k, input logic [3:0] v, input string nm);
    exp_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s unexpected event value=%b", nm, v);
    end else begin
      e = exp_q.pop_front();
      if (e.k != k || e.v != v) begin
        n_fail++;
        $display("FAIL %s got kind=%0d value=%b want kind=%0d value=%b", nm, k, v, e.k, e.v);
      end
    end
  endtask
  always @(negedge clock) begin
    if (!reset) begin
      n_vec++;
      if (outs !== 14'd0) begin
        n_fail++;
        $display("FAIL reset_outputs got %b want 0", outs);
      end
      req_prev = 1'b0;
      busy_prev = 1'b0;
      stall_prev = 1'b0;
    end else begin
      if (bus.dispense_req && !req_prev) begin
        check_ev(K_DISP, {2'b00, bus.dispense_id}, "dispense");
        n_vec++;
        if (cyc - sel_cyc != 2) begin
          n_fail++;
          $display("FAIL disp_latency got %0d want 2", cyc - sel_cyc);
        end
      end
      if (stall_prev && bus.coin_valid) begin
        n_vec++;
        if (bus.coin_type !== type_prev) begin
          n_fail++;
          $display("FAIL coin_stable got %b want %b", bus.coin_type, type_prev);
        end
      end
      if (bus.coin_valid && bus.coin_ready) check_ev(K_COIN, bus.coin_type, "coin");
      if (bus.credit_clear) check_ev(K_CLR, 4'd0, "credit_clear");
      if (busy_prev && !bus.busy) check_ev(K_END, bus.error, "end_error");
      req_prev = bus.dispense_req;
      busy_prev = bus.busy;
      stall_prev = bus.coin_valid && !bus.coin_ready;
      type_prev = bus.coin_type;
    end
  end
  task automatic sel(input logic [15:0] tot, input logic [1:0] id, input logic [3:0] se);
    bus.total = tot;
    bus.stock_empty = se;
    bus.select_id = id;
    bus.select_valid = 1'b1;
    sel_cyc = cyc;
    step();
    bus.select_valid = 1'b0;
  endtask
  task automatic ack_vend();
    int t = 0;
    while (!bus.dispense_req && t < 10) begin
      step();
      t++;
    end
    bus.dispense_ack = 1'b1;
    step();
    bus.dispense_ack = 1'b0;
  endtask
  task automatic wait_idle(input string nm);
    int t = 0;
    while (bus.busy && t < 400) begin
      step();
      t++;
    end
    n_vec++;
    if (bus.busy) begin
      n_fail++;
      $display("FAIL %s busy=1 after %0d cycles want 0", nm, t);
    end
    step();
  endtask
  task automatic check_val(input string nm, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask
  initial begin
    int n, t;
    bus.total = 16'd0;
    bus.select_valid = 1'b0;
    bus.select_id = 2'd0;
    bus.stock_empty = 4'd0;
    bus.dispense_ack = 1'b0;
    bus.coin_ready = 1'b1;
`ifdef CANCEL_EN
    bus.cancel = 1'b0;
`endif
    #1 reset = 1'b0;
    step(2);
    reset = 1'b1;
    step();
    // exact credit: no coins
    expect_ev(K_DISP, 4'd1);
    expect_ev(K_CLR, 4'd0);
    expect_ev(K_END, 4'd0);
    sel(16'd2000, 2'd1, 4'd0);
    ack_vend();
    wait_idle("exact");
    // 8500 - 1500 = 7000 -> 5000, 2000
    expect_ev(K_DISP, 4'd0);
    expect_ev(K_COIN, 4'b1000);
    expect_ev(K_COIN, 4'b0100);
    expect_ev(K_CLR, 4'd0);
    expect_ev(K_END, 4'd0);
    sel(16'd8500, 2'd0, 4'd0);
    ack_vend();
    wait_idle("change");
    // low credit
    expect_ev(K_END, 4'b0001);
    sel(16'd1000, 2'd2, 4'd0);
    step();
    check_val("lowcred_busy", int'(bus.busy), 0);
    step(3);
    check_val("error_sticky", int'(bus.error), 1);
    // sold out beats low credit? here credit is enough; sold out wins
    expect_ev(K_END, 4'b0010);
    sel(16'd5000, 2'd2, 4'b0100);
    wait_idle("soldout");
    expect_ev(K_END, 4'b0010);
    sel(16'd100, 2'd2, 4'b0100);
    wait_idle("soldout_vs_low");
    // invalid id beats sold out
    expect_ev(K_END, 4'b0100);
    sel(16'd9000, 2'd3, 4'b1000);
    wait_idle("invalid");
    // back-pressure: 5000 - 2000 = 3000 -> 2000, 1000
    bus.coin_ready = 1'b0;
    expect_ev(K_DISP, 4'd1);
    expect_ev(K_COIN, 4'b0100);
    expect_ev(K_COIN, 4'b0010);
    expect_ev(K_CLR, 4'd0);
    expect_ev(K_END, 4'd0);
    sel(16'd5000, 2'd1, 4'd0);
    ack_vend();
    t = 0;
    while (!bus.coin_valid && t < 10) begin
      step();
      t++;
    end
    step(3);
    bus.coin_ready = 1'b1;
    wait_idle("backpressure");
    // timeout: no ack
    expect_ev(K_DISP, 4'd1);
    expect_ev(K_END, 4'b1000);
    sel(16'd5000, 2'd1, 4'd0);
    n = 0;
    t = 0;
    while (bus.busy && t < 400) begin
      if (bus.dispense_req) n++;
      step();
      t++;
    end
    check_val("timeout_req_cycles", n, 255);
    step();
    // reset in CHANGE right after the first coin
    expect_ev(K_DISP, 4'd0);
    expect_ev(K_COIN, 4'b1000);
    sel(16'd8500, 2'd0, 4'd0);
    ack_vend();
    t = 0;
    while (!bus.coin_valid && t < 10) begin
      step();
      t++;
    end
    step();
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    step();
`ifdef CANCEL_EN
    expect_ev(K_COIN, 4'b0100);
    expect_ev(K_COIN, 4'b0010);
    expect_ev(K_COIN, 4'b0001);
    expect_ev(K_CLR, 4'd0);
    expect_ev(K_END, 4'd0);
    bus.total = 16'd3500;
    bus.cancel = 1'b1;
    step();
    bus.cancel = 1'b0;
    wait_idle("cancel");
`endif
    step(3);
    check_val("pending_events", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
